// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and the fetch FSM state type.
package instr_fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter
  import instr_fetch_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential fetch from a one-cycle-latency memory, one-bubble redirects,
// halt on Ack, and a saturating cycle counter covering FILL and RUN.
module instr_fetch #(
  parameter int PC_W    = instr_fetch_pkg::PC_W,
  parameter int INSTR_W = instr_fetch_pkg::INSTR_W,
  parameter int CNT_W   = instr_fetch_pkg::CNT_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    Start_Addr,
  output logic [PC_W-1:0]    Imem_Addr,
  input  logic [INSTR_W-1:0] Imem_Data,
  output logic [INSTR_W-1:0] Instruction,
  output logic               Instr_Valid,
  output logic [PC_W-1:0]    Instr_PC,
  input  logic               PC_Jmp_Flag,
  input  logic               PC_Beq_Flag,
  input  logic [PC_W-1:0]    Branch_Target,
  input  logic               Ack,
  output logic               Done,
  output logic [CNT_W-1:0]   Cycle_Count
);

  import instr_fetch_pkg::*;

  fetch_state_t      state_q;
  logic [PC_W-1:0]   addr_q;
  logic [PC_W-1:0]   pc_q;
  logic              done_q;

  // Memory data lags the address by one cycle, so the presented PC is last cycle's address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      pc_q <= addr_q;
      if (Start) begin
        addr_q  <= Start_Addr;
        done_q  <= 1'b0;
        state_q <= FILL;
      end else begin
        case (state_q)
          FILL: begin
            addr_q  <= addr_q + 1'b1;
            state_q <= RUN;
          end
          RUN: begin
            if (Ack) begin
              done_q  <= 1'b1;
              state_q <= HALT;
            end else if (PC_Jmp_Flag || PC_Beq_Flag) begin
              addr_q  <= Branch_Target;
              state_q <= FILL;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign Imem_Addr   = addr_q;
  assign Instr_PC    = pc_q;
  assign Done        = done_q;
  assign Instr_Valid = (state_q == RUN);
  assign Instruction = Instr_Valid ? Imem_Data : '0;

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr_i   (Start),
    .en_i    ((state_q == FILL) || (state_q == RUN)),
    .count_o (Cycle_Count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table with a scoreboard queue, plus hand-written
// sequences for asynchronous reset mid-run and cycle counter saturation.
module tb_instr_fetch;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               Start = 1'b0;
  logic [PC_W-1:0]    Start_Addr = '0;
  logic [PC_W-1:0]    Imem_Addr;
  logic [INSTR_W-1:0] Imem_Data;
  logic [INSTR_W-1:0] Instruction;
  logic               Instr_Valid;
  logic [PC_W-1:0]    Instr_PC;
  logic               PC_Jmp_Flag = 1'b0;
  logic               PC_Beq_Flag = 1'b0;
  logic [PC_W-1:0]    Branch_Target = '0;
  logic               Ack = 1'b0;
  logic               Done;
  logic [CNT_W-1:0]   Cycle_Count;

  typedef struct {
    logic             start;
    logic [PC_W-1:0]  saddr;
    logic             jmp;
    logic             beq;
    logic             ack;
    logic [PC_W-1:0]  tgt;
    logic             ev;
    logic [PC_W-1:0]  epc;
    logic [PC_W-1:0]  eaddr;
    logic             edone;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  vec_t tbl[20];
  vec_t seq5[10];
  vec_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  instr_fetch dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Start         (Start),
    .Start_Addr    (Start_Addr),
    .Imem_Addr     (Imem_Addr),
    .Imem_Data     (Imem_Data),
    .Instruction   (Instruction),
    .Instr_Valid   (Instr_Valid),
    .Instr_PC      (Instr_PC),
    .PC_Jmp_Flag   (PC_Jmp_Flag),
    .PC_Beq_Flag   (PC_Beq_Flag),
    .Branch_Target (Branch_Target),
    .Ack           (Ack),
    .Done          (Done),
    .Cycle_Count   (Cycle_Count)
  );

  always #5 Clk = ~Clk;

  // Memory image: word at address a is (a - 0x10), so 0x010..0x014 hold 0x000..0x004.
  function automatic logic [INSTR_W-1:0] memf(input logic [PC_W-1:0] a);
    logic [PC_W-1:0] d;
    d = a - PC_W'(16);
    return d[INSTR_W-1:0];
  endfunction

  always @(posedge Clk) Imem_Data <= memf(Imem_Addr);

  function automatic vec_t row(input int st, input int sa, input int j, input int b, input int ak,
                               input int t, input int ev, input int epc, input int ea,
                               input int ed, input int ec);
    vec_t r;
    r.start = (st != 0);
    r.saddr = PC_W'(sa);
    r.jmp   = (j != 0);
    r.beq   = (b != 0);
    r.ack   = (ak != 0);
    r.tgt   = PC_W'(t);
    r.ev    = (ev != 0);
    r.epc   = PC_W'(epc);
    r.eaddr = PC_W'(ea);
    r.edone = (ed != 0);
    r.ecnt  = CNT_W'(ec);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic [INSTR_W-1:0] ei;
    @(posedge Clk);
    #1;
    Start         = v.start;
    Start_Addr    = v.saddr;
    PC_Jmp_Flag   = v.jmp;
    PC_Beq_Flag   = v.beq;
    Ack           = v.ack;
    Branch_Target = v.tgt;
    sbq.push_back(v);
    @(negedge Clk);
    e  = sbq.pop_front();
    ei = e.ev ? memf(e.epc) : '0;
    chk("valid", idx, 32'(Instr_Valid), 32'(e.ev));
    chk("instr", idx, 32'(Instruction), 32'(ei));
    if (e.ev) chk("pc", idx, 32'(Instr_PC), 32'(e.epc));
    chk("addr", idx, 32'(Imem_Addr), 32'(e.eaddr));
    chk("done", idx, 32'(Done), 32'(e.edone));
    chk("cnt", idx, 32'(Cycle_Count), 32'(e.ecnt));
  endtask

  task automatic chk_reset_vals(input int idx);
    chk("rst_valid", idx, 32'(Instr_Valid), 32'd0);
    chk("rst_instr", idx, 32'(Instruction), 32'd0);
    chk("rst_addr", idx, 32'(Imem_Addr), 32'd0);
    chk("rst_pc", idx, 32'(Instr_PC), 32'd0);
    chk("rst_done", idx, 32'(Done), 32'd0);
    chk("rst_cnt", idx, 32'(Cycle_Count), 32'd0);
  endtask

  initial begin
    //            st sa     j  b  ak tgt    ev epc    addr   dn cnt
    tbl[0]  = row(0, 0,     1, 0, 1, 0,     0, 0,     0,     0, 0);
    tbl[1]  = row(1, 'h010, 0, 0, 0, 0,     0, 0,     0,     0, 0);
    tbl[2]  = row(0, 0,     1, 0, 1, 'h100, 0, 0,     'h010, 0, 0);
    tbl[3]  = row(0, 0,     0, 0, 0, 0,     1, 'h010, 'h011, 0, 1);
    tbl[4]  = row(0, 0,     0, 0, 0, 0,     1, 'h011, 'h012, 0, 2);
    tbl[5]  = row(0, 0,     1, 0, 0, 'h200, 1, 'h012, 'h013, 0, 3);
    tbl[6]  = row(0, 0,     0, 0, 0, 0,     0, 0,     'h200, 0, 4);
    tbl[7]  = row(0, 0,     0, 1, 0, 'h015, 1, 'h200, 'h201, 0, 5);
    tbl[8]  = row(0, 0,     0, 0, 0, 0,     0, 0,     'h015, 0, 6);
    tbl[9]  = row(0, 0,     0, 1, 1, 'h300, 1, 'h015, 'h016, 0, 7);
    tbl[10] = row(0, 0,     1, 0, 0, 'h300, 0, 0,     'h016, 1, 8);
    tbl[11] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h016, 1, 8);
    tbl[12] = row(1, 'h3FE, 0, 0, 0, 0,     0, 0,     'h016, 1, 8);
    tbl[13] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h3FE, 0, 0);
    tbl[14] = row(0, 0,     0, 0, 0, 0,     1, 'h3FE, 'h3FF, 0, 1);
    tbl[15] = row(0, 0,     0, 0, 0, 0,     1, 'h3FF, 'h000, 0, 2);
    tbl[16] = row(1, 'h040, 0, 0, 1, 0,     1, 'h000, 'h001, 0, 3);
    tbl[17] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h040, 0, 0);
    tbl[18] = row(0, 0,     0, 0, 0, 0,     1, 'h040, 'h041, 0, 1);
    tbl[19] = row(0, 0,     0, 0, 0, 0,     1, 'h041, 'h042, 0, 2);

    seq5[0] = row(0, 0,     0, 0, 0, 0,     0, 0,     0,     0, 0);
    seq5[1] = row(0, 0,     0, 0, 0, 0,     0, 0,     0,     0, 0);
    seq5[2] = row(1, 'h080, 0, 0, 0, 0,     0, 0,     0,     0, 0);
    seq5[3] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h080, 0, 0);
    seq5[4] = row(0, 0,     0, 0, 0, 0,     1, 'h080, 'h081, 0, 1);
    seq5[5] = row(1, 'h0A0, 0, 0, 0, 0,     1, 'h081, 'h082, 0, 2);
    seq5[6] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h0A0, 0, 0);
    seq5[7] = row(0, 0,     0, 0, 0, 0,     1, 'h0A0, 'h0A1, 0, 1);
    seq5[8] = row(1, 'h000, 0, 0, 0, 0,     1, 'h0A1, 'h0A2, 0, 2);
    seq5[9] = row(0, 0,     0, 0, 0, 0,     0, 0,     'h000, 0, 0);

    #12;
    chk_reset_vals(0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i], i);

    // Asynchronous reset in the middle of a RUN cycle, away from any clock edge.
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals(1);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) apply(seq5[i], 100 + i);

    // seq5[9] observed FILL with count 0; each further cycle in RUN adds one.
    repeat (65534) @(posedge Clk);
    @(negedge Clk);
    chk("sat_fffe", 0, 32'(Cycle_Count), 32'h0000_FFFE);
    chk("sat_valid", 0, 32'(Instr_Valid), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    chk("sat_ffff", 0, 32'(Cycle_Count), 32'h0000_FFFF);
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    chk("sat_hold", 0, 32'(Cycle_Count), 32'h0000_FFFF);
    @(posedge Clk);
    #1;
    Ack = 1'b1;
    @(posedge Clk);
    #1;
    Ack = 1'b0;
    @(negedge Clk);
    chk("sat_done", 0, 32'(Done), 32'd1);
    chk("sat_halt_valid", 0, 32'(Instr_Valid), 32'd0);
    chk("sat_halt_cnt", 0, 32'(Cycle_Count), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line, name / default / meaning:
- PC_W / 10 / program counter and instruction-memory address width
- INSTR_W / 9 / instruction width
- CNT_W / 16 / cycle counter width
REQ-003 Ports SHALL be, one per line, name / direction / width / meaning:
- Clk / in / 1 / clock, rising edge
- Reset_n / in / 1 / asynchronous active-low reset
- Start / in / 1 / begin program at Start_Addr
- Start_Addr / in / PC_W / first instruction address
- Imem_Addr / out / PC_W / instruction-memory read address, registered
- Imem_Data / in / INSTR_W / memory data, valid one cycle after Imem_Addr
- Instruction / out / INSTR_W / instruction presented to the decoder
- Instr_Valid / out / 1 / Instruction is live and must execute this cycle
- Instr_PC / out / PC_W / address of the presented instruction
- PC_Jmp_Flag / in / 1 / unconditional redirect from the decoder
- PC_Beq_Flag / in / 1 / taken-branch redirect from the decoder
- Branch_Target / in / PC_W / redirect target from the branch LUT
- Ack / in / 1 / halt request from the decoder
- Done / out / 1 / program halted
- Cycle_Count / out / CNT_W / cycles spent since the last Start

Function
REQ-004 The FSM SHALL have four states: IDLE, FILL, RUN and HALT.
REQ-005 In FILL, Imem_Addr SHALL hold a new fetch address, Instr_Valid SHALL be 0, and the next state SHALL be RUN with Imem_Addr incremented.
REQ-006 In RUN, Instr_Valid SHALL be 1, Instruction SHALL equal Imem_Data, and Instr_PC SHALL equal Imem_Addr from the previous cycle.
REQ-007 In RUN with no redirect and no Ack, Imem_Addr SHALL increment by 1 each cycle, wrapping from 2^PC_W-1 to 0.
REQ-008 In RUN, PC_Jmp_Flag or PC_Beq_Flag (either or both) SHALL set Imem_Addr to Branch_Target and move the FSM to FILL. The sequentially fetched word is squashed, giving exactly one bubble.
REQ-009 In RUN, Ack SHALL move the FSM to HALT, freeze Imem_Addr, and set Done to 1 from the next cycle.
REQ-010 If Ack and a redirect occur together, Ack SHALL win.
REQ-011 PC_Jmp_Flag, PC_Beq_Flag and Ack SHALL be ignored whenever Instr_Valid is 0.
REQ-012 Start SHALL have the highest priority in every state. It SHALL:
- load Imem_Addr with Start_Addr;
- clear Done and Cycle_Count;
- enter FILL.
A Start during RUN aborts the current program.
REQ-013 In IDLE and HALT, Instr_Valid SHALL be 0 and Imem_Addr SHALL hold its value.
REQ-014 Done SHALL stay at 1 in HALT until the next Start.
REQ-015 Cycle_Count SHALL increment in FILL and RUN, saturate at 2^CNT_W-1, and hold in IDLE and HALT.
REQ-016 Instruction SHALL be driven to all zeros whenever Instr_Valid is 0, so a squashed word never reaches the decoder.
REQ-017 Instruction latency from Start to the first Instr_Valid SHALL be exactly 2 cycles: the Start cycle, then FILL.

Reset
REQ-018 While Reset_n is 0, the block SHALL hold: state IDLE, Imem_Addr 0, Done 0, Cycle_Count 0, Instr_Valid 0, Instr_PC 0.
REQ-019 Reset assertion mid-RUN SHALL take effect immediately without waiting for a clock edge. After release, the block SHALL stay in IDLE until Start.

Structure
REQ-020 The fetch state enum (fetch_state_t) and the constants PC_W and INSTR_W SHALL live in the shared Definitions package.
REQ-021 The saturating Cycle_Count logic SHALL be a sub-module named sat_counter. Everything else SHALL be flat.

Verification
REQ-022 Scenario 1, start and sequential run:
- Stimulus: reset, Start with Start_Addr=0x010, memory holding 0x000..0x004 at 0x010..0x014.
- Response: Instr_Valid rises 2 cycles after Start; Instr_PC runs 0x010, 0x011, ... with no gaps.
REQ-023 Scenario 2, jump:
- Stimulus: PC_Jmp_Flag with Branch_Target=0x200 while Instr_PC=0x012.
- Response: next cycle Instr_Valid=0 and Instruction=0; the cycle after that, Instr_PC=0x200.
REQ-024 Scenario 3, Ack with simultaneous branch:
- Stimulus: Ack and PC_Beq_Flag in the same cycle at Instr_PC=0x015.
- Response: HALT, Done=1 next cycle, Imem_Addr frozen, Cycle_Count frozen.
REQ-025 Scenario 4, wrap-around:
- Stimulus: Start_Addr=0x3FE.
- Response: Instr_PC sequence 0x3FE, 0x3FF, 0x000.
REQ-026 Scenario 5, reset mid-run:
- Stimulus: Reset_n pulled low mid-RUN between clock edges, then Start asserted during RUN.
- Response: the reset immediately forces IDLE with all outputs at reset values. Start during RUN restarts at the new Start_Addr with Cycle_Count=0.
REQ-027 Scenario 6, counter saturation:
- Stimulus: force a run longer than 65535 cycles.
- Response: Cycle_Count holds at 0xFFFF.
